// File: rtl/rob.sv
// Reorder buffer: allocates entries in program order, captures CDB results and
// retires the head entry once its value is ready (at most one commit per cycle).
module rob #(
   parameter int ROB_DEPTH = 16,
   parameter int IDX_W     = $clog2(ROB_DEPTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             alloc_valid,
   output logic             alloc_ready,
   input  logic [6:0]       alloc_op,
   input  logic [4:0]       alloc_rd,
   output logic [IDX_W-1:0] alloc_tag,
   input  logic             cdb_valid,
   input  logic [IDX_W-1:0] cdb_tag,
   input  logic [31:0]      cdb_value,
   input  logic [IDX_W-1:0] rd_tag,
   output logic             rd_ready,
   output logic [31:0]      rd_value,
   output logic             commit_valid,
   output logic [IDX_W-1:0] commit_tag,
   output logic [6:0]       commit_op,
   output logic [4:0]       commit_rd,
   output logic [31:0]      commit_value,
   input  logic             flush
);

   typedef struct packed {
      logic [6:0]  op;
      logic [4:0]  rd;
      logic [31:0] value;
   } rob_entry_t;

   rob_entry_t           r_entries [ROB_DEPTH];
   logic [ROB_DEPTH-1:0] r_valid;
   logic [ROB_DEPTH-1:0] r_ready;
   logic [IDX_W:0]       r_head;
   logic [IDX_W:0]       r_tail;

   logic [IDX_W-1:0] w_head_idx;
   logic [IDX_W-1:0] w_tail_idx;
   logic             w_empty;
   logic             w_full;
   logic             w_alloc;
   logic             w_cdb_wr;
   logic             w_commit;
   rob_entry_t       w_head_entry;

   assign w_head_idx   = r_head[IDX_W-1:0];
   assign w_tail_idx   = r_tail[IDX_W-1:0];
   assign w_empty      = (r_head == r_tail);
   assign w_full       = (w_head_idx == w_tail_idx) && (r_head[IDX_W] != r_tail[IDX_W]);
   assign w_head_entry = r_entries[w_head_idx];

   // Full is judged before any same-cycle commit, so a full ROB refuses one extra cycle.
   assign alloc_ready = rst && !w_full;
   assign alloc_tag   = rst ? w_tail_idx : '0;
   assign w_alloc     = alloc_valid && alloc_ready;
   assign w_cdb_wr    = cdb_valid && r_valid[cdb_tag];
   assign w_commit    = rst && !flush && !w_empty && r_valid[w_head_idx] && r_ready[w_head_idx];

   assign commit_valid = w_commit;
   assign commit_tag   = w_commit ? w_head_idx         : '0;
   assign commit_op    = w_commit ? w_head_entry.op    : '0;
   assign commit_rd    = w_commit ? w_head_entry.rd    : '0;
   assign commit_value = w_commit ? w_head_entry.value : '0;

   // NOTE: combinational blocks use blocking '=' and assign every output a default first, so no latch is inferred.
   always_comb begin
      rd_ready = 1'b0;
      rd_value = r_entries[rd_tag].value;
      if (rst && cdb_valid && (cdb_tag == rd_tag) && r_valid[rd_tag]) begin
         rd_ready = 1'b1;
         rd_value = cdb_value;
      end else begin
         rd_ready = rst && r_valid[rd_tag] && r_ready[rd_tag];
      end
   end

   // NOTE: sequential state uses non-blocking '<=' so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!rst || flush) begin
         r_valid <= '0;
         r_ready <= '0;
         r_head  <= '0;
         r_tail  <= '0;
      end else begin
         if (w_alloc) begin
            r_valid[w_tail_idx] <= 1'b1;
            r_ready[w_tail_idx] <= 1'b0;
            r_tail              <= r_tail + 1'b1;
         end
         if (w_cdb_wr) begin
            r_ready[cdb_tag] <= 1'b1;
         end
         if (w_commit) begin
            r_valid[w_head_idx] <= 1'b0;
            r_ready[w_head_idx] <= 1'b0;
            r_head              <= r_head + 1'b1;
         end
      end
   end

   // NOTE: the payload array has no reset; valid/ready bits alone decide whether its contents mean anything.
   always_ff @(posedge clk) begin
      if (rst && !flush) begin
         if (w_alloc) begin
            r_entries[w_tail_idx] <= '{op: alloc_op, rd: alloc_rd, value: 32'h0};
         end
         if (w_cdb_wr) begin
            r_entries[cdb_tag].value <= cdb_value;
         end
      end
   end

endmodule
